// File: rtl/frame_detector_mc.sv
// Multi-channel frame detector: hunts for HEADER, checks length and CRC-16/CCITT,
// stores good frames in a two-bank ping-pong buffer and replays them on a
// valid/ready stream (optionally Gray-coded) with channel mask and SOF/EOF.
module frame_detector_mc #(
    parameter int              DATA_W    = 16,
    parameter int              CH_NUM    = 8,
    parameter int              MAX_WORDS = 8,
    parameter logic [DATA_W-1:0] HEADER  = DATA_W'(16'hE0E0),
    parameter bit              GRAY_EN   = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_vld,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_NUM-1:0] out_ch_mask,
    output logic              out_sof,
    output logic              out_eof,
    output logic              crc_err,
    output logic              len_err,
    output logic              frame_drop,
    output logic              buf_full,
    output logic              buf_empty,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
);

    localparam int         DEPTH   = 2 * MAX_WORDS;
    localparam int         ADDR_W  = $clog2(DEPTH);
    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    typedef enum logic [1:0] {RX_HUNT, RX_LEN, RX_DATA, RX_CRC} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

    // One beat of CRC-16/CCITT (poly 0x1021), word fed MSB first.
    function automatic logic [15:0] crc_fold(input logic [15:0] crc, input logic [DATA_W-1:0] word);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    rx_state_t             rx_state_q, rx_state_d;
    logic [7:0]            rx_cnt_q, rx_cnt_d;
    logic [7:0]            rx_len_q, rx_len_d;
    logic [CH_NUM-1:0]     rx_mask_q, rx_mask_d;
    logic [15:0]           crc_q, crc_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [1:0][CH_NUM-1:0] bank_mask_q, bank_mask_d;
    logic [1:0][7:0]       bank_len_q, bank_len_d;
    tx_state_t             tx_state_q, tx_state_d;
    logic [7:0]            tx_idx_q, tx_idx_d;
    logic                  crc_err_q, crc_err_d;
    logic                  len_err_q, len_err_d;
    logic                  frame_drop_q, frame_drop_d;
    logic                  buf_full_q, buf_full_d;
    logic                  buf_empty_q, buf_empty_d;
    logic [15:0]           good_cnt_q, good_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rd_data_q;
    logic                  mem_we;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_base;
    logic [ADDR_W-1:0]     rd_base;
    logic                  rx_commit;
    logic                  tx_free;
    logic [7:0]            len_field;
    logic [7:0]            cur_len;
    logic                  tx_last;

    assign wr_base   = wr_bank_q ? ADDR_W'(MAX_WORDS) : '0;
    assign rd_base   = rd_bank_q ? ADDR_W'(MAX_WORDS) : '0;
    assign len_field = data_in[7:0];
    assign cur_len   = bank_len_q[rd_bank_q];
    assign tx_last   = (tx_idx_q == cur_len - 8'd1);

    // Receive FSM: header hunt, length check, payload capture, CRC verdict.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_len_d     = rx_len_q;
        rx_mask_d    = rx_mask_q;
        crc_d        = crc_q;
        wr_bank_d    = wr_bank_q;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
        frame_drop_d = 1'b0;
        good_cnt_d   = good_cnt_q;
        err_cnt_d    = err_cnt_q;
        mem_we       = 1'b0;
        wr_addr      = wr_base + ADDR_W'(rx_cnt_q);
        rx_commit    = 1'b0;
        if (data_in_vld) begin
            case (rx_state_q)
                RX_HUNT: begin
                    if (data_in == HEADER) begin
                        // Only both-full blocks a frame: banks fill and drain in order.
                        if (&bank_full_q) frame_drop_d = 1'b1;
                        else              rx_state_d   = RX_LEN;
                    end
                end
                RX_LEN: begin
                    if (len_field == 8'd0 || len_field > MAX_LEN) begin
                        len_err_d  = 1'b1;
                        err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        rx_state_d = RX_HUNT;
                    end else begin
                        rx_mask_d  = data_in[DATA_W-1 -: CH_NUM];
                        rx_len_d   = len_field;
                        rx_cnt_d   = 8'd0;
                        crc_d      = crc_fold(16'hFFFF, data_in);
                        rx_state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    mem_we   = 1'b1;
                    crc_d    = crc_fold(crc_q, data_in);
                    rx_cnt_d = rx_cnt_q + 8'd1;
                    if (rx_cnt_q == rx_len_q - 8'd1) rx_state_d = RX_CRC;
                end
                RX_CRC: begin
                    if (data_in[15:0] == crc_q) begin
                        rx_commit  = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        good_cnt_d = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
                    end else begin
                        crc_err_d  = 1'b1;
                        err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    end
                    rx_state_d = RX_HUNT;
                end
                default: rx_state_d = RX_HUNT;
            endcase
        end
    end

    // Transmit FSM: prefetches the next word so the registered RAM read lines up with the handshake.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        rd_bank_d  = rd_bank_q;
        rd_en      = 1'b0;
        rd_addr    = rd_base + ADDR_W'(tx_idx_q);
        tx_free    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    tx_state_d = TX_SEND;
                    tx_idx_d   = 8'd0;
                    rd_en      = 1'b1;
                    rd_addr    = rd_base;
                end
            end
            TX_SEND: begin
                if (out_ready) begin
                    if (tx_last) begin
                        tx_free    = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 8'd1;
                        rd_en    = 1'b1;
                        rd_addr  = rd_base + ADDR_W'(tx_idx_q + 8'd1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Bank bookkeeping: RX fills the write bank while TX frees the read bank; they never collide.
    always_comb begin
        bank_full_d = bank_full_q;
        bank_mask_d = bank_mask_q;
        bank_len_d  = bank_len_q;
        if (rx_commit) begin
            bank_full_d[wr_bank_q] = 1'b1;
            bank_mask_d[wr_bank_q] = rx_mask_q;
            bank_len_d[wr_bank_q]  = rx_len_q;
        end
        if (tx_free) bank_full_d[rd_bank_q] = 1'b0;
        buf_full_d  = &bank_full_q;
        buf_empty_d = ~|bank_full_q;
    end

    // State and status registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rx_state_q   <= RX_HUNT;
            rx_cnt_q     <= '0;
            rx_len_q     <= '0;
            rx_mask_q    <= '0;
            crc_q        <= 16'hFFFF;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= '0;
            bank_mask_q  <= '0;
            bank_len_q   <= '0;
            tx_state_q   <= TX_IDLE;
            tx_idx_q     <= '0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            frame_drop_q <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_empty_q  <= 1'b1;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_len_q     <= rx_len_d;
            rx_mask_q    <= rx_mask_d;
            crc_q        <= crc_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bank_full_q  <= bank_full_d;
            bank_mask_q  <= bank_mask_d;
            bank_len_q   <= bank_len_d;
            tx_state_q   <= tx_state_d;
            tx_idx_q     <= tx_idx_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            frame_drop_q <= frame_drop_d;
            buf_full_q   <= buf_full_d;
            buf_empty_q  <= buf_empty_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Payload RAM write port.
    always_ff @(posedge clk_in) begin
        if (mem_we) mem[wr_addr] <= data_in;
    end

    // Payload RAM registered read; holds its value while the output is stalled.
    always_ff @(posedge clk_in) begin
        if (!rst_n)     rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign out_valid   = (tx_state_q == TX_SEND);
    assign out_data    = !out_valid ? '0 : (GRAY_EN ? (rd_data_q ^ (rd_data_q >> 1)) : rd_data_q);
    assign out_ch_mask = out_valid ? bank_mask_q[rd_bank_q] : '0;
    assign out_sof     = out_valid && (tx_idx_q == 8'd0);
    assign out_eof     = out_valid && tx_last;
    assign crc_err     = crc_err_q;
    assign len_err     = len_err_q;
    assign frame_drop  = frame_drop_q;
    assign buf_full    = buf_full_q;
    assign buf_empty   = buf_empty_q;
    assign good_cnt    = good_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_frame_detector_mc.sv
// Directed bench for frame_detector_mc (DATA_W=16, CH_NUM=8, MAX_WORDS=8, GRAY_EN=1).
module tb_frame_detector_mc;

    localparam logic [15:0] HDR = 16'hE0E0;
    localparam logic [15:0] F2_GRAY [8] = '{16'h0018, 16'h0019, 16'h001B, 16'h001A,
                                            16'h001E, 16'h001F, 16'h001D, 16'h001C};

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_in_vld;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_ch_mask;
    logic        out_sof;
    logic        out_eof;
    logic        crc_err;
    logic        len_err;
    logic        frame_drop;
    logic        buf_full;
    logic        buf_empty;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    frame_detector_mc dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_in_vld (data_in_vld),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ch_mask (out_ch_mask),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .frame_drop  (frame_drop),
        .buf_full    (buf_full),
        .buf_empty   (buf_empty),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    logic [15:0] pl [16];
    int          crc_pulses = 0;
    int          len_pulses = 0;
    int          drop_pulses = 0;
    bit          saw_valid = 1'b0;
    bit          saw_not_empty = 1'b0;
    bit          rnd_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Output monitor: records handshaken beats, counts pulses, checks stall stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_beat;
        logic [31:0] cur;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk_in);
            cur = {6'd0, out_eof, out_sof, out_ch_mask, out_data};
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_beat", cur, prev_beat);
            end
            if (rst_n === 1'b1) begin
                if (out_valid && out_ready) begin
                    got_q.push_back(cur);
                    $display("beat data=%h mask=%h sof=%0d eof=%0d", out_data, out_ch_mask, out_sof, out_eof);
                end
                if (crc_err)    crc_pulses++;
                if (len_err)    len_pulses++;
                if (frame_drop) drop_pulses++;
                if (out_valid)  saw_valid = 1'b1;
                if (!buf_empty) saw_not_empty = 1'b1;
            end
            prev_stall = (rst_n === 1'b1) && out_valid && !out_ready;
            prev_beat  = cur;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic put(input logic [15:0] w, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int i = 0; i < g; i++) begin
            tick();
            data_in_vld = 1'b0;
            data_in     = 16'($urandom);
        end
        tick();
        data_in     = w;
        data_in_vld = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            data_in_vld = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] len, input int n, input logic [15:0] crc_xor, input int max_gap);
        logic [15:0] c;
        put(HDR, max_gap);
        put(len, max_gap);
        c = crc_upd(16'hFFFF, len);
        for (int i = 0; i < n; i++) begin
            put(pl[i], max_gap);
            c = crc_upd(c, pl[i]);
        end
        put(c ^ crc_xor, max_gap);
        tick();
        data_in_vld = 1'b0;
        $display("frame len=%h n=%0d crc_xor=%h sent", len, n, crc_xor);
    endtask

    task automatic expect_frame(input logic [7:0] mask, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({6'd0, (i == n - 1), (i == 0), mask, pl[i] ^ (pl[i] >> 1)});
    endtask

    task automatic drain_cmp(input string tag, input int budget);
        int k;
        k = 0;
        while (got_q.size() < exp_q.size() && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        idle(4);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_beat"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_mask"}, 32'(out_ch_mask), 32'd0);
        chk({tag, "_sof"}, 32'(out_sof), 32'd0);
        chk({tag, "_eof"}, 32'(out_eof), 32'd0);
        chk({tag, "_crc_err"}, 32'(crc_err), 32'd0);
        chk({tag, "_len_err"}, 32'(len_err), 32'd0);
        chk({tag, "_drop"}, 32'(frame_drop), 32'd0);
        chk({tag, "_full"}, 32'(buf_full), 32'd0);
        chk({tag, "_empty"}, 32'(buf_empty), 32'd1);
        chk({tag, "_good"}, 32'(good_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        data_in     = '0;
        data_in_vld = 1'b0;
        out_ready   = 1'b1;
        rnd_done    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        idle(2);

        // Good frame with exact latency
        pl[0] = 16'h0001; pl[1] = 16'h0002; pl[2] = 16'h0003;
        exp_q.push_back(32'h0105_0001);
        exp_q.push_back(32'h0005_0003);
        exp_q.push_back(32'h0205_0002);
        send_frame(16'h0503, 3, 16'h0000, 0);
        @(negedge clk_in);
        chk("good_lat1_valid", 32'(out_valid), 32'd0);
        chk("good_cnt_1", 32'(good_cnt), 32'd1);
        chk("good_lat1_empty", 32'(buf_empty), 32'd1);
        @(negedge clk_in);
        chk("good_lat2_valid", 32'(out_valid), 32'd1);
        chk("good_lat2_sof", 32'(out_sof), 32'd1);
        chk("good_lat2_empty", 32'(buf_empty), 32'd0);
        drain_cmp("good", 50);
        chk("good_empty_end", 32'(buf_empty), 32'd1);
        chk("good_err_cnt", 32'(err_cnt), 32'd0);

        // CRC error
        crc_pulses = 0; saw_valid = 1'b0; saw_not_empty = 1'b0;
        send_frame(16'h0503, 3, 16'h0001, 0);
        @(negedge clk_in);
        chk("crc_err_pulse", 32'(crc_err), 32'd1);
        chk("crc_err_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk_in);
        chk("crc_err_low", 32'(crc_err), 32'd0);
        idle(8);
        chk("crc_pulse_count", 32'(crc_pulses), 32'd1);
        chk("crc_no_valid", 32'(saw_valid), 32'd0);
        chk("crc_empty_held", 32'(saw_not_empty), 32'd0);
        chk("crc_good_cnt", 32'(good_cnt), 32'd1);

        // Length errors: N=0 and N=MAX_WORDS+1, then a good frame
        len_pulses = 0; saw_valid = 1'b0;
        put(HDR, 0);
        put(16'h0500, 0);
        tick();
        data_in_vld = 1'b0;
        @(negedge clk_in);
        chk("len0_pulse", 32'(len_err), 32'd1);
        put(HDR, 0);
        put(16'h0109, 0);
        for (int i = 0; i < 9; i++) put(16'h0100 + 16'(i), 0);
        idle(4);
        chk("len_pulse_count", 32'(len_pulses), 32'd2);
        chk("len_err_cnt", 32'(err_cnt), 32'd3);
        chk("len_no_valid", 32'(saw_valid), 32'd0);
        pl[0] = 16'h00FF;
        exp_q.push_back(32'h03FF_0080);
        send_frame(16'hFF01, 1, 16'h0000, 0);
        drain_cmp("after_len", 50);
        chk("after_len_good", 32'(good_cnt), 32'd2);

        // Back-pressure: fill both banks, drop the third frame
        tick();
        out_ready = 1'b0;
        drop_pulses = 0;
        pl[0] = 16'hA001; pl[1] = 16'hA002;
        exp_q.push_back(32'h0101_F001);
        exp_q.push_back(32'h0201_F003);
        send_frame(16'h0102, 2, 16'h0000, 0);
        idle(3);
        chk("bp_not_full_1", 32'(buf_full), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pl[i] = 16'h0010 + 16'(i);
            exp_q.push_back({6'd0, (i == 7), (i == 0), 8'h02, F2_GRAY[i]});
        end
        send_frame(16'h0208, 8, 16'h0000, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        chk("bp_full", 32'(buf_full), 32'd1);
        chk("bp_not_empty", 32'(buf_empty), 32'd0);
        put(HDR, 0);
        tick();
        data_in_vld = 1'b0;
        @(negedge clk_in);
        chk("bp_drop_pulse", 32'(frame_drop), 32'd1);
        put(16'h0401, 0);
        put(16'h3333, 0);
        idle(4);
        chk("bp_drop_count", 32'(drop_pulses), 32'd1);
        chk("bp_good_cnt", 32'(good_cnt), 32'd4);
        chk("bp_stalled_count", 32'(got_q.size()), 32'd0);
        tick();
        out_ready = 1'b1;
        drain_cmp("bp", 100);
        chk("bp_empty_end", 32'(buf_empty), 32'd1);

        // Random input gaps and ready toggling against the model
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    logic [7:0] m;
                    int         n;
                    int         k;
                    m = 8'($urandom);
                    n = int'($urandom_range(1, 8));
                    for (int i = 0; i < n; i++) pl[i] = 16'($urandom);
                    idle(2);
                    k = 0;
                    while (buf_full && k < 300) begin
                        tick();
                        k++;
                    end
                    chk("rnd_full_wait", 32'(buf_full), 32'd0);
                    put(16'h1234, 3);
                    expect_frame(m, n);
                    send_frame({m, 8'(n)}, n, 16'h0000, 3);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain_cmp("rnd", 300);
        chk("rnd_good_cnt", 32'(good_cnt), 32'd10);

        // Reset mid-payload discards buffered and partial frames
        tick();
        out_ready = 1'b0;
        pl[0] = 16'h0F0F;
        send_frame(16'h1001, 1, 16'h0000, 0);
        put(HDR, 0);
        put(16'h0304, 0);
        put(16'h1111, 0);
        put(16'h2222, 0);
        tick();
        rst_n       = 1'b0;
        data_in_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk_in);
        chk_reset_vals("midrst");
        got_q.delete();
        exp_q.delete();
        tick();
        out_ready = 1'b1;
        pl[0] = 16'h4321;
        exp_q.push_back(32'h0320_62B1);
        send_frame(16'h2001, 1, 16'h0000, 0);
        drain_cmp("post_rst", 50);
        chk("post_rst_good", 32'(good_cnt), 32'd1);
        chk("post_rst_err", 32'(err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
